// File: rtl/lm32_itlb_refill.sv
// ITLB refill engine: walks a single-level page table over a Wishbone classic
// read port and writes {valid, tag, pfn} into the ITLB RAM, or reports a fault.
module lm32_itlb_refill #(
    parameter int unsigned itlb_sets      = 1024,
    parameter int unsigned page_size      = 4096,
    parameter int unsigned timeout_cycles = 256,
    localparam int unsigned IW = $clog2(itlb_sets),
    localparam int unsigned OW = $clog2(page_size),
    localparam int unsigned TW = 1 + (32 - OW - IW) + (32 - OW),
    localparam int unsigned CW = $clog2(timeout_cycles + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic [31:0]   ptbr_i,
    input  logic          miss_i,
    input  logic [31:0]   miss_vaddr_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          refill_done_o,
    output logic          refill_fault_o,
    output logic [1:0]    fault_cause_o,
    output logic [31:0]   fault_vaddr_o,
    output logic          tlb_we_o,
    output logic [IW-1:0] tlb_index_o,
    output logic [TW-1:0] tlb_wdata_o,
    output logic [31:0]   pw_adr_o,
    output logic          pw_cyc_o,
    output logic          pw_stb_o,
    input  logic [31:0]   pw_dat_i,
    input  logic          pw_ack_i,
    input  logic          pw_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS,
        S_WRITE,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] CAUSE_INVALID = 2'b01;
    localparam logic [1:0] CAUSE_BUSERR  = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [31:0]   adr_q, adr_n;
    logic [31:0]   vaddr_q, vaddr_n;
    logic [31:OW]  pte_q, pte_n;
    logic [1:0]    cause_q, cause_n;
    logic [31:0]   fvaddr_q, fvaddr_n;
    logic          busy_q, cyc_q, we_q, done_q, fault_q;

    // Byte-address alignment bits and PTE flag bits other than valid carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{ptbr_i[1:0], pw_dat_i[OW-1:1]};

    // Next-state and datapath updates; flush overrides everything and never records a fault.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        adr_n    = adr_q;
        vaddr_n  = vaddr_q;
        pte_n    = pte_q;
        cause_n  = cause_q;
        fvaddr_n = fvaddr_q;
        case (state)
            S_IDLE: begin
                if (miss_i && enable_i) begin
                    vaddr_n = miss_vaddr_i;
                    adr_n   = {ptbr_i[31:2], 2'b00} + 32'({miss_vaddr_i[31:OW], 2'b00});
                    cnt_n   = '0;
                    state_n = S_BUS;
                end
            end
            S_BUS: begin
                if (pw_err_i) begin
                    cause_n  = CAUSE_BUSERR;
                    fvaddr_n = vaddr_q;
                    state_n  = S_FAULT;
                end else if (pw_ack_i) begin
                    pte_n = pw_dat_i[31:OW];
                    if (pw_dat_i[0]) begin
                        state_n = S_WRITE;
                    end else begin
                        cause_n  = CAUSE_INVALID;
                        fvaddr_n = vaddr_q;
                        state_n  = S_FAULT;
                    end
                end else if (cnt == CW'(timeout_cycles - 1)) begin
                    cause_n  = CAUSE_TIMEOUT;
                    fvaddr_n = vaddr_q;
                    state_n  = S_FAULT;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            S_WRITE: state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            S_FAULT: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (flush_i) begin
            state_n  = S_IDLE;
            cause_n  = cause_q;
            fvaddr_n = fvaddr_q;
        end
    end

    // State, datapath and registered output flags decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= S_IDLE;
            cnt      <= '0;
            adr_q    <= '0;
            vaddr_q  <= '0;
            pte_q    <= '0;
            cause_q  <= '0;
            fvaddr_q <= '0;
            busy_q   <= 1'b0;
            cyc_q    <= 1'b0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            adr_q    <= adr_n;
            vaddr_q  <= vaddr_n;
            pte_q    <= pte_n;
            cause_q  <= cause_n;
            fvaddr_q <= fvaddr_n;
            busy_q   <= (state_n != S_IDLE);
            cyc_q    <= (state_n == S_BUS);
            we_q     <= (state_n == S_WRITE);
            done_q   <= (state_n == S_DONE);
            fault_q  <= (state_n == S_FAULT);
        end
    end

    // A flush arriving in the write cycle must kill the write in that same cycle.
    assign tlb_we_o       = we_q && !flush_i;
    assign tlb_index_o    = vaddr_q[OW+IW-1:OW];
    assign tlb_wdata_o    = {1'b1, vaddr_q[31:OW+IW], pte_q};
    assign busy_o         = busy_q;
    assign refill_done_o  = done_q;
    assign refill_fault_o = fault_q;
    assign fault_cause_o  = cause_q;
    assign fault_vaddr_o  = fvaddr_q;
    assign pw_adr_o       = adr_q;
    assign pw_cyc_o       = cyc_q;
    assign pw_stb_o       = cyc_q;

endmodule
